// File: rtl/req10_arbiter.sv
// ----------------------------------------------------------------------------
// req10_arbiter : 10-way round-robin arbiter with a per-grant watchdog
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module req10_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] req,
  input  logic       done,
  output logic [9:0] grant,
  output logic [3:0] grant_id,
  output logic       busy,
  output logic       timeout
);

  localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);
  localparam logic [3:0] C_NO_HOLDER = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] ptr_q, ptr_d;
  logic [3:0] holder_q, holder_d;
  logic [7:0] wdog_q, wdog_d;
  logic [9:0] grant_q, grant_d;
  logic [3:0] grant_id_q, grant_id_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;

  logic [4:0] sel;
  logic [7:0] wdog_inc;
  logic       expire;
  logic       holder_req;

  // Returns {found, index} of the first set bit at or above p, wrapping 9 -> 0.
  function automatic logic [4:0] pick(input logic [9:0] r, input logic [3:0] p);
    logic [4:0] c;
    pick = 5'd0;
    for (int k = 9; k >= 0; k--) begin
      c = 5'(p) + 5'(k);
      if (c >= 5'd10) c = c - 5'd10;
      if (r[c[3:0]]) pick = {1'b1, c[3:0]};
    end
  endfunction

  always_comb begin
    sel        = pick(req, ptr_q);
    wdog_inc   = wdog_q + 8'd1;
    expire     = (wdog_inc == C_TIMEOUT);
    holder_req = req[holder_q];
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    holder_d   = holder_q;
    wdog_d     = wdog_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel[4]) begin
          state_d    = ST_GRANT;
          holder_d   = sel[3:0];
          wdog_d     = 8'd0;
          grant_d    = 10'h001 << sel[3:0];
          grant_id_d = sel[3:0] + 4'd1;
          busy_d     = 1'b1;
        end
      end
      ST_GRANT: begin
        wdog_d = wdog_inc;
        if (done || !holder_req || expire) begin
          state_d    = ST_GAP;
          ptr_d      = (holder_q == 4'd9) ? 4'd0 : holder_q + 4'd1;
          grant_d    = 10'h000;
          grant_id_d = C_NO_HOLDER;
          busy_d     = 1'b0;
          // A normal release on the expiry cycle wins over the watchdog.
          timeout_d  = expire && !done && holder_req;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        grant_d    = 10'h000;
        grant_id_d = C_NO_HOLDER;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 4'd0;
      holder_q   <= 4'd0;
      wdog_q     <= 8'd0;
      grant_q    <= 10'h000;
      grant_id_q <= C_NO_HOLDER;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      holder_q   <= holder_d;
      wdog_q     <= wdog_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;

endmodule

`default_nettype wire

// File: doc/req10_arbiter.md
REQ10_ARBITER -- requirements
Module: req10_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, range 1..255: the maximum number of GRANT cycles before a grant is forcibly revoked.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset; assertion takes effect immediately, deassertion is synchronised by the source.
REQ-004 req  input  10  request vector; bit i = requester i wants the shared resource.
REQ-005 done  input  1  the current holder releases the resource; sampled only in GRANT.
REQ-006 grant  output  10  one-hot grant vector, registered; all-zero when no holder.
REQ-007 grant_id  output  4  registered encoded holder: requester i -> i+1 (1..10); 4'b1111 when no holder.
REQ-008 busy  output  1  registered; 1 exactly when grant is non-zero.
REQ-009 timeout  output  1  registered single-cycle pulse on a forced release.

Function
REQ-010 The FSM SHALL have three states: IDLE, GRANT, GAP.
REQ-011 IDLE: when req != 0, SHALL select the first set bit at or above index ptr, wrapping 9 -> 0, and enter GRANT; grant/grant_id/busy SHALL be valid in the cycle after req was sampled (1-cycle latency).
REQ-012 IDLE with req == 0 SHALL remain in IDLE with outputs at their idle values.
REQ-013 GRANT SHALL hold grant, grant_id and busy constant while the holder's req bit stays 1, done = 0 and the watchdog has not expired.
REQ-014 GRANT SHALL release on the first of: done = 1, the holder's req bit = 0, or the watchdog count reaching TIMEOUT; release moves the FSM to GAP.
REQ-015 The watchdog counter (8 bits) SHALL clear on GRANT entry, increment once per GRANT cycle, and expire on the cycle it equals TIMEOUT.
REQ-016 When done (or holder req drop) coincides with watchdog expiry, the release SHALL count as normal and timeout SHALL stay 0.
REQ-017 A forced release SHALL assert timeout for exactly the one cycle in which the FSM is in GAP.
REQ-018 GAP SHALL last exactly one cycle with grant = 0, grant_id = 4'b1111, busy = 0, then return to IDLE.
REQ-019 On every release, ptr SHALL be set to (holder index + 1) mod 10, giving round-robin fairness.
REQ-020 Requests from non-holders during GRANT or GAP SHALL be ignored until IDLE; no request queueing.
REQ-021 grant SHALL never have more than one bit set, and grant_id SHALL always equal the encoded value of grant.

Reset
REQ-022 While rst_n = 0: FSM = IDLE, ptr = 0, watchdog = 0, grant = 0, grant_id = 4'b1111, busy = 0, timeout = 0.
REQ-023 Reset asserted mid-GRANT SHALL drop grant immediately, with no GAP cycle and no timeout pulse.
REQ-024 The first arbitration after reset SHALL favour requester 0.

Verification
REQ-025 Reset, then req = 10'h3FF for 1 cycle, then held -> grant = 10'h001, grant_id = 1 one cycle after sampling.
REQ-026 req = 10'h3FF held, done pulsed 1 cycle each grant -> grant_id sequence 1,2,...,10,1, each separated by one GAP cycle with grant_id = 15.
REQ-027 TIMEOUT = 4, req = 10'h020, done = 0 -> grant_id = 6 for 4 cycles, then GAP with timeout = 1 for one cycle, then re-grant to 6.
REQ-028 TIMEOUT = 4, done = 1 on the expiry cycle -> release, timeout stays 0.
REQ-029 Holder 3 (grant_id = 4) drops req[3] while req[7] is set -> GAP, then grant_id = 8.
REQ-030 rst_n pulled low mid-GRANT -> grant = 0, grant_id = 15 without waiting for a clock edge; after release, req = 10'h200 gives grant_id = 10.
